pe_stream_driver: RTL and testbench

Producer-side sequencer for the PE datapath. It buffers host-supplied (weight, activation) pairs in an internal FIFO, then drives exactly `itr` consecutive beats per neuron onto the PE `weight`/`iact` inputs. It waits for the PE `done` flag, captures the quantized N/2-bit result, and hands it back to the host over a valid/ready channel. It sits between the host/DMA stream and one PE instance, and owns the PE's per-neuron reset.

---
 rtl/pe_stream_driver.sv | 190 +++++++++++++++++++
 tb/tb_pe_stream_driver.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_stream_driver.sv
// pe_stream_driver: buffers host (weight, activation) pairs in a FIFO and
// replays them to a PE as contiguous groups of itr beats per neuron. It then
// waits for the PE completion flag (or a timeout) and returns the quantized
// result to the host over a valid/ready channel.
`timescale 1ns/1ps
module pe_stream_driver #(
    parameter int N       = 16,
    parameter int itr     = 8,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_weight,
    input  logic [N-1:0]     in_iact,
    output logic             pe_rst,
    output logic [N-1:0]     pe_weight,
    output logic [N-1:0]     pe_iact,
    output logic             pe_beat,
    input  logic [N/2-1:0]   pe_outp,
    input  logic             pe_done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [N/2-1:0]   res_data,
    output logic [7:0]       res_tag,
    output logic             res_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int BW = (itr > 1) ? $clog2(itr) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_WAIT,
        S_RESULT
    } state_t;

    // FIFO storage and bookkeeping
    logic [2*N-1:0] mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  count_d;
    logic           push;
    logic           pop;

    // Sequencer state and registered outputs
    state_t         state_q;
    logic [BW-1:0]  beat_q;
    logic [7:0]     timer_q;
    logic           pe_rst_q;
    logic           pe_beat_q;
    logic [N-1:0]   pe_weight_q;
    logic [N-1:0]   pe_iact_q;
    logic           res_valid_q;
    logic [N/2-1:0] res_data_q;
    logic [7:0]     res_tag_q;
    logic           res_err_q;

    // Ready is derived straight from the occupancy so a full FIFO refuses
    // the pair in the very cycle it becomes full.
    assign in_ready = (count_q != CW'(DEPTH));
    assign push     = in_valid && in_ready;
    // A whole beat group is buffered before STREAM starts, so popping
    // unconditionally in STREAM can never underflow.
    assign pop      = (state_q == S_STREAM);

    // Occupancy next-state: simultaneous push and pop leave it unchanged
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO write port; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= {in_weight, in_iact};
        end
    end

    // FIFO pointers and occupancy; reset discards everything buffered
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    // Neuron sequencer with registered PE and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            timer_q     <= '0;
            pe_rst_q    <= 1'b0;
            pe_beat_q   <= 1'b0;
            pe_weight_q <= '0;
            pe_iact_q   <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_tag_q   <= '0;
            res_err_q   <= 1'b0;
        end else begin
            // Strobes and beat data default low so the PE bus is idle at 0
            pe_rst_q    <= 1'b0;
            pe_beat_q   <= 1'b0;
            pe_weight_q <= '0;
            pe_iact_q   <= '0;
            case (state_q)
                S_IDLE: begin
                    if (count_q >= CW'(itr)) begin
                        state_q  <= S_CLEAR;
                        pe_rst_q <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    state_q <= S_STREAM;
                    beat_q  <= '0;
                end
                S_STREAM: begin
                    // Registered read of the head pair: it reaches the PE next cycle
                    pe_beat_q                <= 1'b1;
                    {pe_weight_q, pe_iact_q} <= mem_q[rd_ptr_q];
                    if (beat_q == BW'(itr - 1)) begin
                        state_q <= S_WAIT;
                        beat_q  <= '0;
                        timer_q <= '0;
                    end else begin
                        beat_q <= beat_q + BW'(1);
                    end
                end
                S_WAIT: begin
                    // A completion in the same cycle the timer expires still wins
                    if (pe_done) begin
                        res_data_q  <= pe_outp;
                        res_err_q   <= 1'b0;
                        res_valid_q <= 1'b1;
                        state_q     <= S_RESULT;
                    end else if (timer_q == 8'(TIMEOUT)) begin
                        res_data_q  <= '0;
                        res_err_q   <= 1'b1;
                        res_valid_q <= 1'b1;
                        state_q     <= S_RESULT;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                S_RESULT: begin
                    // Result fields are held untouched until the host takes them
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        res_tag_q   <= res_tag_q + 8'd1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign pe_rst    = pe_rst_q;
    assign pe_beat   = pe_beat_q;
    assign pe_weight = pe_weight_q;
    assign pe_iact   = pe_iact_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_tag   = res_tag_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_pe_stream_driver.sv
// Testbench for pe_stream_driver: table-driven neurons plus hand-written
// sequences for under-fill, backpressure, FIFO full, mid-stream reset and
// result tag wrap.
`timescale 1ns/1ps
module tb_pe_stream_driver;

    localparam int N     = 16;
    localparam int ITR   = 4;
    localparam int DEPTH = 16;
    localparam int TMO   = 10;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N-1:0]   in_weight = '0;
    logic [N-1:0]   in_iact = '0;
    logic           pe_rst;
    logic [N-1:0]   pe_weight;
    logic [N-1:0]   pe_iact;
    logic           pe_beat;
    logic [N/2-1:0] pe_outp = '0;
    logic           pe_done = 1'b0;
    logic           res_valid;
    logic           res_ready = 1'b0;
    logic [N/2-1:0] res_data;
    logic [7:0]     res_tag;
    logic           res_err;

    always #5 clk = ~clk;

    pe_stream_driver #(
        .N(N), .itr(ITR), .DEPTH(DEPTH), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_weight(in_weight), .in_iact(in_iact),
        .pe_rst(pe_rst), .pe_weight(pe_weight), .pe_iact(pe_iact), .pe_beat(pe_beat),
        .pe_outp(pe_outp), .pe_done(pe_done),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_tag(res_tag), .res_err(res_err)
    );

    typedef struct packed {
        logic [N-1:0] w;
        logic [N-1:0] a;
    } pair_t;

    typedef struct {
        logic [N-1:0] w [ITR];
        logic [N-1:0] a [ITR];
        logic [7:0]   outp;
        int           d;        // cycles after WAIT entry before pe_done; -1 = never
        logic         noise;    // hold pe_done high outside WAIT
        logic [7:0]   exp_data;
        logic         exp_err;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         rst_cnt = 0;
    int         beat_cnt = 0;
    logic [7:0] tag_exp = 8'd0;
    pair_t      exp_q [$];
    vec_t       vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and check the PE beat bus against the pushed pairs
    task automatic tick();
        pair_t p;
        @(posedge clk);
        #2;
        if (pe_rst) rst_cnt++;
        if (pe_beat) begin
            beat_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat_unexpected: got w=%0h a=%0h with no pair outstanding", pe_weight, pe_iact);
            end else begin
                p = exp_q.pop_front();
                chk("beat_weight", pe_weight, p.w);
                chk("beat_iact", pe_iact, p.a);
            end
        end else begin
            chk("idle_bus_zero", {pe_weight, pe_iact}, 32'd0);
        end
    endtask

    task automatic push_pair(input logic [N-1:0] w, input logic [N-1:0] a);
        pair_t p;
        chk("push_in_ready", in_ready, 1);
        in_valid  = 1'b1;
        in_weight = w;
        in_iact   = a;
        p.w = w;
        p.a = a;
        exp_q.push_back(p);
        tick();
        in_valid = 1'b0;
        $display("push w=%0h a=%0h", w, a);
    endtask

    // Wait for the neuron's pe_rst, check the beat group and produce the result
    task automatic serve_result(input int d, input logic [7:0] outp, input logic [7:0] exp_data,
                                input logic exp_err, output int lat);
        lat = 0;
        while (lat < 60) begin
            tick();
            lat++;
            if (pe_rst) break;
        end
        chk("pe_rst_seen", pe_rst, 1);
        tick();
        chk("pe_rst_one_cycle", pe_rst, 0);
        chk("clear_gap_no_beat", pe_beat, 0);
        for (int i = 0; i < ITR; i++) begin
            tick();
            chk("beat_strobe", pe_beat, 1);
        end
        pe_done = 1'b0;
        chk("no_early_result", res_valid, 0);
        if (d < 0) begin
            for (int i = 0; i < TMO; i++) tick();
            chk("timeout_not_yet", res_valid, 0);
            tick();
        end else begin
            for (int i = 0; i < d; i++) tick();
            pe_done = 1'b1;
            pe_outp = outp;
            tick();
            pe_done = 1'b0;
            pe_outp = ~outp;
        end
        chk("res_valid", res_valid, 1);
        chk("res_data", res_data, exp_data);
        chk("res_err", res_err, exp_err);
        chk("res_tag", res_tag, tag_exp);
        $display("result tag=%0d data=%0h err=%0b lat=%0d", res_tag, res_data, res_err, lat);
    endtask

    task automatic accept();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tag_exp = tag_exp + 8'd1;
        chk("res_valid_drop", res_valid, 0);
        chk("res_tag_next", res_tag, tag_exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int rc;
        int bc;

        // {pairs, pe_outp, done delay, noise, expected data, expected err}
        vecs[0].w = '{16'd1, 16'd3, 16'd5, 16'd7};
        vecs[0].a = '{16'd2, 16'd4, 16'd6, 16'd8};
        vecs[0].outp = 8'h2C; vecs[0].d = 2;  vecs[0].noise = 0; vecs[0].exp_data = 8'h2C; vecs[0].exp_err = 0;
        vecs[1].w = '{16'hFFFF, 16'h8000, 16'h0001, 16'h7FFF};
        vecs[1].a = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h1234};
        vecs[1].outp = 8'hFF; vecs[1].d = 0;  vecs[1].noise = 0; vecs[1].exp_data = 8'hFF; vecs[1].exp_err = 0;
        vecs[2].w = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
        vecs[2].a = '{16'h0050, 16'h0060, 16'h0070, 16'h0080};
        vecs[2].outp = 8'h80; vecs[2].d = 10; vecs[2].noise = 0; vecs[2].exp_data = 8'h80; vecs[2].exp_err = 0;
        vecs[3].w = '{16'h000A, 16'h000B, 16'h000C, 16'h000D};
        vecs[3].a = '{16'h0001, 16'h0001, 16'h0001, 16'h0001};
        vecs[3].outp = 8'h33; vecs[3].d = -1; vecs[3].noise = 0; vecs[3].exp_data = 8'h00; vecs[3].exp_err = 1;
        vecs[4].w = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
        vecs[4].a = '{16'h0004, 16'h0003, 16'h0002, 16'h0001};
        vecs[4].outp = 8'h01; vecs[4].d = 3;  vecs[4].noise = 1; vecs[4].exp_data = 8'h01; vecs[4].exp_err = 0;

        // Reset values
        rst = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_pe_rst", pe_rst, 0);
        chk("rst_pe_beat", pe_beat, 0);
        chk("rst_pe_bus", {pe_weight, pe_iact}, 32'd0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_tag", res_tag, 0);
        chk("rst_res_err", res_err, 0);
        rst = 1'b0;
        tick();

        // Table-driven neurons
        for (int v = 0; v < 5; v++) begin
            rc = rst_cnt;
            if (vecs[v].noise) begin
                pe_done = 1'b1;
                pe_outp = 8'hEE;
            end
            for (int i = 0; i < ITR; i++) push_pair(vecs[v].w[i], vecs[v].a[i]);
            serve_result(vecs[v].d, vecs[v].outp, vecs[v].exp_data, vecs[v].exp_err, lat);
            chk("rst_latency", lat, 1);
            chk("pe_rst_once", rst_cnt - rc, 1);
            accept();
        end

        // Under-fill: itr-1 pairs never start a neuron
        rc = rst_cnt;
        bc = beat_cnt;
        for (int i = 0; i < ITR - 1; i++) push_pair(16'h0A00 + 16'(i), 16'h0B00 + 16'(i));
        for (int i = 0; i < 50; i++) tick();
        chk("underfill_no_rst", rst_cnt, rc);
        chk("underfill_no_beat", beat_cnt, bc);
        push_pair(16'h0A03, 16'h0B03);
        serve_result(2, 8'h44, 8'h44, 0, lat);
        chk("underfill_rst_latency", lat, 1);
        accept();

        // Backpressure: result held, no new neuron while unaccepted
        for (int i = 0; i < ITR; i++) push_pair(16'h0C00 + 16'(i), 16'h0D00 + 16'(i));
        serve_result(1, 8'h5A, 8'h5A, 0, lat);
        for (int i = 0; i < ITR; i++) push_pair(16'h0E00 + 16'(i), 16'h0F00 + 16'(i));
        rc = rst_cnt;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_res_valid", res_valid, 1);
            chk("bp_res_data", res_data, 8'h5A);
            chk("bp_res_tag", res_tag, tag_exp);
        end
        chk("bp_no_pe_rst", rst_cnt, rc);
        accept();
        serve_result(1, 8'h66, 8'h66, 0, lat);
        chk("bp_rst_after_accept", lat, 1);
        accept();

        // FIFO full while the previous result is unaccepted
        for (int i = 0; i < ITR; i++) push_pair(16'h1100 + 16'(i), 16'h1200 + 16'(i));
        serve_result(2, 8'h11, 8'h11, 0, lat);
        for (int i = 0; i < DEPTH; i++) push_pair(16'h1000 + 16'(i), 16'h2000 + 16'(i));
        chk("full_in_ready_low", in_ready, 0);
        in_valid  = 1'b1;
        in_weight = 16'hDEAD;
        in_iact   = 16'hBEEF;
        tick();
        in_valid = 1'b0;
        chk("full_17th_rejected", in_ready, 0);
        chk("full_res_hold", res_valid, 1);
        accept();
        tick();
        chk("full_pe_rst", pe_rst, 1);
        tick();
        chk("full_pop0_in_ready", in_ready, 0);
        bc = beat_cnt;
        tick();
        chk("after_pop_in_ready", in_ready, 1);
        for (int i = 0; i < ITR - 1; i++) push_pair(16'h3000 + 16'(i), 16'h4000 + 16'(i));
        chk("push_pop_in_ready", in_ready, 1);
        chk("full_beats", beat_cnt - bc, ITR);
        push_pair(16'h3003, 16'h4003);
        chk("refull_in_ready", in_ready, 0);
        pe_done = 1'b1;
        pe_outp = 8'h22;
        tick();
        pe_done = 1'b0;
        chk("full_res_valid", res_valid, 1);
        chk("full_res_data", res_data, 8'h22);
        chk("full_res_tag", res_tag, tag_exp);
        accept();
        for (int n = 0; n < 4; n++) begin
            serve_result(1, 8'h30 + 8'(n), 8'h30 + 8'(n), 0, lat);
            chk("drain_rst_latency", lat, 1);
            accept();
        end
        chk("drain_empty", exp_q.size(), 0);

        // Mid-stream reset on the second beat
        for (int i = 0; i < ITR; i++) push_pair(16'h5000 + 16'(i), 16'h6000 + 16'(i));
        lat = 0;
        while (lat < 60) begin
            tick();
            lat++;
            if (pe_rst) break;
        end
        chk("mid_pe_rst_seen", pe_rst, 1);
        tick();
        tick();
        tick();
        chk("mid_second_beat", pe_beat, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        tag_exp = 8'd0;
        chk("mid_pe_beat", pe_beat, 0);
        chk("mid_in_ready", in_ready, 1);
        chk("mid_res_valid", res_valid, 0);
        chk("mid_res_tag", res_tag, 0);
        for (int i = 0; i < ITR; i++) push_pair(16'h7000 + 16'(i), 16'h8000 + 16'(i));
        serve_result(1, 8'h77, 8'h77, 0, lat);
        chk("mid_rst_latency", lat, 1);
        chk("mid_only_fresh", exp_q.size(), 0);
        accept();

        // Tag wrap: 257 neurons from a fresh reset, tags 0..255 then 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tag_exp = 8'd0;
        exp_q.delete();
        for (int k = 0; k < 257; k++) begin
            for (int i = 0; i < ITR; i++) push_pair(16'(k), 16'(i + 1));
            serve_result(1, 8'(k), 8'(k), 0, lat);
            accept();
        end
        chk("wrap_final_tag", res_tag, 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
